i2s_audio_tx: RTL and testbench



---
 rtl/i2s_audio_tx_pkg.sv | 17 +
 rtl/i2s_bclk_gen.sv | 44 ++++
 rtl/i2s_audio_tx.sv | 145 ++++++++++++++
 tb/tb_i2s_audio_tx.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_audio_tx_pkg.sv
// Shared audio constants and types for the I2S transmitter.
// The bit and slot counter widths are derived from the frame geometry.
package i2s_audio_tx_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;
    localparam int SAMPLE_W       = 16;
    localparam int GAIN_UNITY     = 256;

    // Width of the bit counter, which covers one full frame (6 bits).
    localparam int BIT_CNT_W = $clog2(I2S_FRAME_BITS);
    // Width of the position inside one channel slot (5 bits).
    localparam int SLOT_W    = $clog2(I2S_SLOT_BITS);

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit-clock divider for the I2S transmitter.
// bclk is a registered data output that toggles every BCLK_HALF clk24 cycles.
// fall_evt is high in the clk24 cycle whose closing edge drives bclk from 1 to 0.
module i2s_bclk_gen
    import i2s_audio_tx_pkg::*;
#(
    parameter int BCLK_HALF = 4
) (
    input  logic clk24,
    input  logic rst_n,
    output logic bclk,
    output logic fall_evt
);

    localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);

    logic [7:0] div_cnt_q;
    logic [7:0] div_cnt_d;
    logic       bclk_q;
    logic       bclk_d;
    logic       div_tc;

    // Wrap the divider at its terminal count and toggle bclk on that wrap.
    always_comb begin
        div_tc    = (div_cnt_q == DIV_LAST);
        div_cnt_d = div_tc ? 8'd0 : div_cnt_q + 8'd1;
        bclk_d    = div_tc ? ~bclk_q : bclk_q;
    end

    // Divider state; reset leaves bclk low, so the first edge is a rise.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= 8'd0;
            bclk_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
        end
    end

    assign bclk     = bclk_q;
    assign fall_evt = div_tc & bclk_q;

endmodule

// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter: the mono sample is duplicated to left and right.
// One sample is captured per 64-bit frame, and frame_strobe marks each capture.
// Optional macro SOFT_MUTE_EN: mute ramps a 0..256 gain instead of forcing zero.
module i2s_audio_tx #(
    parameter int BCLK_HALF = 4,
    parameter int GAIN_STEP = 1
) (
    input  logic        clk24,
    input  logic        rst_n,
    input  logic [15:0] sample_in,
    input  logic        mute,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic        frame_strobe
);

    import i2s_audio_tx_pkg::*;

    localparam bit PARAMS_OK = (BCLK_HALF >= 1) && (BCLK_HALF <= 255) &&
                               (GAIN_STEP >= 1) && (GAIN_STEP <= GAIN_UNITY);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("i2s_audio_tx: BCLK_HALF must be 1..255 and GAIN_STEP 1..256");
        end
    endgenerate

    logic                 bclk_fall;
    logic                 capture;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_nxt;
    logic [SLOT_W-1:0]    slot;
    logic [3:0]           bit_idx;
    logic                 lrclk_q;
    logic                 lrclk_d;
    logic                 sdata_q;
    logic                 sdata_d;
    logic                 frame_strobe_q;
    logic                 frame_strobe_d;
    sample_t              held_q;
    sample_t              held_d;
    sample_t              held_new;

    i2s_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .clk24    (clk24),
        .rst_n    (rst_n),
        .bclk     (bclk),
        .fall_evt (bclk_fall)
    );

    // A capture happens on the falling bclk edge where the frame counter wraps.
    assign capture = bclk_fall && (bit_cnt_q == BIT_CNT_W'(I2S_FRAME_BITS - 1));

`ifdef SOFT_MUTE_EN
    localparam logic [9:0] STEP_W  = 10'(GAIN_STEP);
    localparam logic [9:0] UNITY_W = 10'(GAIN_UNITY);

    logic        [8:0]  gain_q;
    logic        [8:0]  gain_d;
    logic        [9:0]  gain_up;
    logic signed [24:0] sample_ext;
    logic signed [24:0] gain_ext;
    logic signed [24:0] product;

    // Scale by the current gain, then step the gain toward 256 or 0 on capture.
    always_comb begin
        sample_ext = {{9{sample_in[15]}}, sample_in};
        gain_ext   = {16'd0, gain_q};
        product    = sample_ext * gain_ext;
        held_new   = product[23:8];
        gain_up    = {1'b0, gain_q} + STEP_W;
        gain_d     = gain_q;
        if (capture) begin
            if (mute) begin
                gain_d = ({1'b0, gain_q} < STEP_W) ? 9'd0 : gain_q - STEP_W[8:0];
            end else begin
                gain_d = (gain_up > UNITY_W) ? UNITY_W[8:0] : gain_up[8:0];
            end
        end
    end

    // Gain register; it starts at zero, so audio fades in after reset.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            gain_q <= 9'd0;
        end else begin
            gain_q <= gain_d;
        end
    end
`else
    // Hard mute: the captured value is either the sample or silence.
    always_comb begin
        held_new = mute ? sample_t'(0) : sample_t'(sample_in);
    end
`endif

    // Frame sequencing: bit counter, word select and serial data all move on
    // the falling bclk edge, so the DAC sees them stable at the next rise.
    // Slot position 0 is left empty to give the one-bit I2S delay.
    always_comb begin
        bit_cnt_nxt    = bit_cnt_q + BIT_CNT_W'(1);
        slot           = bit_cnt_nxt[SLOT_W-1:0];
        bit_idx        = 4'(SLOT_W'(SAMPLE_W) - slot);
        bit_cnt_d      = bit_cnt_q;
        lrclk_d        = lrclk_q;
        sdata_d        = sdata_q;
        frame_strobe_d = capture;
        held_d         = capture ? held_new : held_q;
        if (bclk_fall) begin
            bit_cnt_d = bit_cnt_nxt;
            lrclk_d   = bit_cnt_nxt[BIT_CNT_W-1];
            if ((slot != '0) && (slot <= SLOT_W'(SAMPLE_W))) begin
                sdata_d = held_q[bit_idx];
            end else begin
                sdata_d = 1'b0;
            end
        end
    end

    // Frame state registers; reset returns every output to idle immediately.
    always_ff @(posedge clk24 or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q      <= '0;
            lrclk_q        <= 1'b0;
            sdata_q        <= 1'b0;
            frame_strobe_q <= 1'b0;
            held_q         <= '0;
        end else begin
            bit_cnt_q      <= bit_cnt_d;
            lrclk_q        <= lrclk_d;
            sdata_q        <= sdata_d;
            frame_strobe_q <= frame_strobe_d;
            held_q         <= held_d;
        end
    end

    assign lrclk        = lrclk_q;
    assign sdata        = sdata_q;
    assign frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx. The bench decodes each frame at the
// rising bclk edges and checks both slots, the word select and the padding.
// The bench also checks strobe spacing, reset behaviour and mid-frame input changes.
module tb_i2s_audio_tx;

    localparam int BCLK_HALF = 4;
    localparam int GAIN_STEP = 64;
    localparam int FRAME_CYC = 128 * BCLK_HALF;

    logic        clk24 = 1'b0;
    logic        rst_n;
    logic [15:0] sample_in;
    logic        mute;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        frame_strobe;

    int          testsRun    = 0;
    int          testsFailed = 0;
    int          cyc         = 0;
    int          refTime     = 0;
    int          gainM       = 0;
    logic [15:0] expHeld     = 16'h0;

    typedef struct {
        logic [15:0] sample;
        logic        mute;
        logic [15:0] expWord;
    } vec_t;

`ifdef SOFT_MUTE_EN
    localparam int NVEC = 12;
`else
    localparam int NVEC = 8;
`endif
    vec_t vecs[NVEC];

    // Free-running clock and a cycle counter for the strobe spacing checks.
    always #5 clk24 = ~clk24;

    always @(posedge clk24) cyc <= cyc + 1;

    i2s_audio_tx #(
        .BCLK_HALF (BCLK_HALF),
        .GAIN_STEP (GAIN_STEP)
    ) dut (
        .clk24        (clk24),
        .rst_n        (rst_n),
        .sample_in    (sample_in),
        .mute         (mute),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata),
        .frame_strobe (frame_strobe)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] s, input logic m);
        sample_in = s;
        mute      = m;
    endtask

    // Reference for the value that a capture loads into the held register.
    task automatic modelCapture(input logic [15:0] s, input logic m);
`ifdef SOFT_MUTE_EN
        int prod;
        prod    = int'($signed(s)) * gainM;
        expHeld = 16'(prod >>> 8);
        if (m) gainM = (gainM > GAIN_STEP) ? gainM - GAIN_STEP : 0;
        else   gainM = (gainM + GAIN_STEP > 256) ? 256 : gainM + GAIN_STEP;
`else
        expHeld = m ? 16'h0000 : s;
`endif
    endtask

    // Wait for the next capture, then check its spacing and its one-cycle width.
    task automatic waitStrobe(input int expGap, input bit expectQuiet);
        bit seen   = 1'b0;
        bit sawOne = 1'b0;
        int t;
        for (int i = 0; i < FRAME_CYC + 64 && !seen; i++) begin
            @(negedge clk24);
            if (sdata === 1'b1) sawOne = 1'b1;
            if (frame_strobe === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL strobe_timeout: no frame_strobe within %0d cycles", FRAME_CYC + 64);
            return;
        end
        t = cyc;
        checkOutput("strobe_gap", t - refTime, expGap);
        refTime = t;
        if (expectQuiet) checkOutput("quiet_frame_sdata", 32'(sawOne), 32'd0);
        modelCapture(sample_in, mute);
        @(negedge clk24);
        checkOutput("strobe_width", 32'(frame_strobe), 32'd0);
    endtask

    // Decode the 64 slots after a strobe, optionally changing inputs at one slot.
    task automatic readFrame(input int actSlot, input logic [15:0] actSample,
                             input logic actMute, output logic [15:0] leftW,
                             output logic [15:0] rightW, output bit lrOk,
                             output bit padOk);
        int   slotN = 0;
        int   guard = 0;
        int   s;
        logic prevB;
        leftW  = 16'h0;
        rightW = 16'h0;
        lrOk   = 1'b1;
        padOk  = 1'b1;
        prevB  = bclk;
        while (slotN < 64 && guard < 2 * FRAME_CYC) begin
            @(negedge clk24);
            guard++;
            if (bclk === 1'b1 && prevB === 1'b0) begin
                if (lrclk !== (slotN >= 32)) lrOk = 1'b0;
                s = slotN % 32;
                if (s >= 1 && s <= 16) begin
                    if (slotN < 32) leftW[16-s] = sdata;
                    else            rightW[16-s] = sdata;
                end else if (sdata !== 1'b0) begin
                    padOk = 1'b0;
                end
                if (slotN == actSlot) applyStimulus(actSample, actMute);
                slotN++;
            end
            prevB = bclk;
        end
        if (slotN < 64) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL frame_timeout: only %0d bclk rises seen", slotN);
        end
    endtask

    task automatic checkFrame(input string name, input logic [15:0] expWord,
                              input int actSlot, input logic [15:0] actSample,
                              input logic actMute);
        logic [15:0] l;
        logic [15:0] r;
        bit          lrOk;
        bit          padOk;
        readFrame(actSlot, actSample, actMute, l, r, lrOk, padOk);
        checkOutput({name, "_left"}, 32'(l), 32'(expWord));
        checkOutput({name, "_right"}, 32'(r), 32'(expWord));
        checkOutput({name, "_lrclk"}, 32'(lrOk), 32'd1);
        checkOutput({name, "_pad"}, 32'(padOk), 32'd1);
    endtask

    initial begin
`ifdef SOFT_MUTE_EN
        vecs[0]  = '{16'h4000, 1'b0, 16'h0000};
        vecs[1]  = '{16'h4000, 1'b0, 16'h1000};
        vecs[2]  = '{16'h4000, 1'b0, 16'h2000};
        vecs[3]  = '{16'h4000, 1'b0, 16'h3000};
        vecs[4]  = '{16'h4000, 1'b0, 16'h4000};
        vecs[5]  = '{16'h4000, 1'b0, 16'h4000};
        vecs[6]  = '{16'h4000, 1'b1, 16'h4000};
        vecs[7]  = '{16'h4000, 1'b1, 16'h3000};
        vecs[8]  = '{16'h4000, 1'b1, 16'h2000};
        vecs[9]  = '{16'h4000, 1'b1, 16'h1000};
        vecs[10] = '{16'h4000, 1'b1, 16'h0000};
        vecs[11] = '{16'h4000, 1'b1, 16'h0000};
`else
        vecs[0] = '{16'hA5C3, 1'b0, 16'hA5C3};
        vecs[1] = '{16'hA5C3, 1'b0, 16'hA5C3};
        vecs[2] = '{16'h8000, 1'b0, 16'h8000};
        vecs[3] = '{16'h7FFF, 1'b0, 16'h7FFF};
        vecs[4] = '{16'h8000, 1'b0, 16'h8000};
        vecs[5] = '{16'h7FFF, 1'b0, 16'h7FFF};
        vecs[6] = '{16'h1234, 1'b1, 16'h0000};
        vecs[7] = '{16'h0001, 1'b0, 16'h0001};
`endif

        rst_n = 1'b0;
        applyStimulus(vecs[0].sample, vecs[0].mute);
        repeat (3) @(negedge clk24);
        checkOutput("reset_bclk", 32'(bclk), 32'd0);
        checkOutput("reset_lrclk", 32'(lrclk), 32'd0);
        checkOutput("reset_sdata", 32'(sdata), 32'd0);
        checkOutput("reset_strobe", 32'(frame_strobe), 32'd0);

        rst_n   = 1'b1;
        refTime = cyc;
        gainM   = 0;
        waitStrobe(FRAME_CYC, 1'b1);

        for (int i = 0; i < NVEC; i++) begin
            checkFrame($sformatf("vec%0d", i), vecs[i].expWord, -1, 16'h0, 1'b0);
            if (i < NVEC - 1) begin
                applyStimulus(vecs[i+1].sample, vecs[i+1].mute);
                waitStrobe(FRAME_CYC, 1'b0);
            end
        end

        // A sample change in mid-frame must wait for the next capture.
        applyStimulus(16'h8000, 1'b0);
        waitStrobe(FRAME_CYC, 1'b0);
        checkFrame("midchg_a", expHeld, 10, 16'h7FFF, 1'b0);
        waitStrobe(FRAME_CYC, 1'b0);
        checkFrame("midchg_b", expHeld, -1, 16'h0, 1'b0);

        // A mute at bit 20 must leave the frame in flight untouched.
        applyStimulus(16'h1234, 1'b0);
        waitStrobe(FRAME_CYC, 1'b0);
        checkFrame("mute_inflight", expHeld, 20, 16'h1234, 1'b1);
        waitStrobe(FRAME_CYC, 1'b0);
        checkFrame("mute_next", expHeld, -1, 16'h0, 1'b0);

        // Assert reset at bit 40: the outputs idle at once and the timing restarts.
        applyStimulus(16'h5A5A, 1'b0);
        waitStrobe(FRAME_CYC, 1'b0);
        begin
            int   rises = 0;
            logic prevB;
            prevB = bclk;
            for (int g = 0; g < 2 * FRAME_CYC && rises < 41; g++) begin
                @(negedge clk24);
                if (bclk === 1'b1 && prevB === 1'b0) rises++;
                prevB = bclk;
            end
            checkOutput("pre_reset_rises", 32'(rises), 32'd41);
        end
        checkOutput("pre_reset_lrclk", 32'(lrclk), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_bclk", 32'(bclk), 32'd0);
        checkOutput("async_reset_lrclk", 32'(lrclk), 32'd0);
        checkOutput("async_reset_sdata", 32'(sdata), 32'd0);
        repeat (2) @(negedge clk24);
        rst_n   = 1'b1;
        refTime = cyc;
        gainM   = 0;
        waitStrobe(FRAME_CYC, 1'b1);
        checkFrame("post_reset", expHeld, -1, 16'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    // Global watchdog in case a bounded wait is ever bypassed.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation exceeded 2 ms");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
